pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 16-bit five-stage pipeline. It drives the write-enable ("hit"), bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions:
- cache-miss freeze
- taken-branch flush (branch resolved in MEM)
- load-use single-cycle bubble

It also keeps a saturating stall-cycle counter and raises a sticky miss-timeout flag.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/load_use_detect.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the controller state encoding and the default register-index width
// used by the top level and the load-use comparator.
package hazard_pkg;

    localparam int HZ_REG_ADDR_W = 3;

    // Two-bit encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FREEZE     = 2'd1,
        FLUSH      = 2'd2,
        LOAD_STALL = 2'd3
    } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator.
// Flags a hazard when the instruction in EX is a load whose destination
// matches a source register that the ID instruction actually reads.
// Register 0 is not special-cased: a match on r0 still stalls.
// Ports:
//   id_rs_i, id_rt_i        source register indices of the ID instruction
//   id_uses_rs_i/_rt_i      ID instruction reads that source
//   ex_mem_read_i           EX instruction is a load
//   ex_rt_i                 load destination in EX
//   hazard_o                load-use hazard present
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    output logic                  hazard_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs_i & (id_rs_i == ex_rt_i);
    assign rt_match = id_uses_rt_i & (id_rt_i == ex_rt_i);
    assign hazard_o = ex_mem_read_i & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Drives the write enables, flushes and bubble of the PC and the four stage
// registers, resolving cache-miss freeze, taken-branch flush and load-use
// bubble (priority: reset > miss > branch > load-use). Also keeps a
// saturating stall-cycle counter and a sticky miss-timeout flag.
// Outputs are combinational from state and inputs; the stage registers
// sample them on the falling edge, the controller updates on the rising edge.
// Ports:
//   clk, reset (sync, active-high)
//   icache_hit, dcache_hit, mem_access   cache status
//   id_rs, id_rt, id_uses_rs, id_uses_rt, ex_MemRead, ex_rt   load-use fields
//   mem_branch_taken                     branch in MEM resolved taken
//   pc_write, *_write, *_flush, id_ex_bubble, pc_sel_branch   pipeline controls
//   stall_cycles, miss_timeout, state_o  status / debug
//
// State table:
//   state      | meaning
//   RUN        | normal flow; all hazards evaluated
//   FREEZE     | at least one miss cycle seen; exits through RUN evaluation
//   FLUSH      | cycle after a taken branch; load-use ignored (ID holds NOP)
//   LOAD_STALL | cycle after a bubble; load-use ignored (EX holds bubble)
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = HZ_REG_ADDR_W,
    parameter int STALL_CNT_W  = 16,
    parameter int MISS_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   icache_hit,
    input  logic                   dcache_hit,
    input  logic                   mem_access,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   ex_MemRead,
    input  logic [REG_ADDR_W-1:0]  ex_rt,
    input  logic                   mem_branch_taken,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_write,
    output logic                   ex_mem_write,
    output logic                   mem_wb_write,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   id_ex_bubble,
    output logic                   pc_sel_branch,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   miss_timeout,
    output logic [1:0]             state_o
);

    // Freeze counter only needs to reach MISS_TIMEOUT, where it parks.
    localparam int FCNT_W = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(MISS_TIMEOUT);

    hz_state_e state_q, state_d;

    logic                   miss;
    logic                   hazard;
    logic                   lu_stall;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic                   timeout_q, timeout_d;

    assign miss = ~icache_hit | (mem_access & ~dcache_hit);

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rs_i  (id_uses_rs),
        .id_uses_rt_i  (id_uses_rt),
        .ex_mem_read_i (ex_MemRead),
        .ex_rt_i       (ex_rt),
        .hazard_o      (hazard)
    );

    // A stall is only taken when nothing of higher priority fires and the
    // previous cycle did not already neutralise ID or EX.
    assign lu_stall = hazard & ~miss & ~mem_branch_taken &
                      ((state_q == RUN) | (state_q == FREEZE));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = RUN;
        if (miss) begin
            state_d = FREEZE;
        end else if (mem_branch_taken) begin
            state_d = FLUSH;
        end else if (lu_stall) begin
            state_d = LOAD_STALL;
        end
    end

    // Output logic
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        mem_wb_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        id_ex_bubble  = 1'b0;
        pc_sel_branch = 1'b0;
        if (reset) begin
            // Drain: every stage register loads a NOP while reset is held.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (miss) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (mem_branch_taken) begin
            pc_sel_branch = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
        end else if (lu_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Stall counter, freeze counter and timeout flag
    always_comb begin
        stall_d = stall_q;
        if ((miss | lu_stall) && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end

        fcnt_d = '0;
        if (miss) begin
            fcnt_d = (fcnt_q == FCNT_MAX) ? fcnt_q : fcnt_q + FCNT_W'(1);
        end

        timeout_d = timeout_q | (fcnt_d == FCNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q   <= '0;
            fcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            fcnt_q    <= fcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_cycles = stall_q;
    assign miss_timeout = timeout_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Each cycle the stimulus
// driver computes the expected controls/status from a reference model and
// queues them; the monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam logic [1:0] S_RUN = 2'd0, S_FREEZE = 2'd1, S_FLUSH = 2'd2, S_LSTALL = 2'd3;
    localparam int TMO = 255;

    typedef struct packed {
        logic [9:0]  ctrl;
        logic [1:0]  st;
        logic [15:0] stall;
        logic        tmo;
    } exp_t;

    logic clk = 1'b1;
    logic reset, icache_hit, dcache_hit, mem_access;
    logic [2:0] id_rs, id_rt, ex_rt;
    logic id_uses_rs, id_uses_rt, ex_MemRead, mem_branch_taken;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble, pc_sel_branch;
    logic [15:0] stall_cycles;
    logic miss_timeout;
    logic [1:0] state_o;

    int n_vec = 0;
    int n_err = 0;
    exp_t sb[$];
    exp_t e_mon;

    logic [1:0]  m_state;
    logic [15:0] m_stall;
    int          m_fcnt;
    logic        m_tmo;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .icache_hit       (icache_hit),
        .dcache_hit       (dcache_hit),
        .mem_access       (mem_access),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .ex_MemRead       (ex_MemRead),
        .ex_rt            (ex_rt),
        .mem_branch_taken (mem_branch_taken),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .id_ex_write      (id_ex_write),
        .ex_mem_write     (ex_mem_write),
        .mem_wb_write     (mem_wb_write),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .id_ex_bubble     (id_ex_bubble),
        .pc_sel_branch    (pc_sel_branch),
        .stall_cycles     (stall_cycles),
        .miss_timeout     (miss_timeout),
        .state_o          (state_o)
    );

    // Control bits: pc, if_id, id_ex, ex_mem, mem_wb writes; 3 flushes; bubble; pc_sel
    localparam logic [9:0] C_DEF   = 10'b11111_000_0_0;
    localparam logic [9:0] C_MISS  = 10'b00000_000_0_0;
    localparam logic [9:0] C_BR    = 10'b11111_111_0_1;
    localparam logic [9:0] C_LU    = 10'b00111_000_1_0;
    localparam logic [9:0] C_DRAIN = 10'b00000_111_1_0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            check_eq("ctrl", 32'({pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                                  if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble, pc_sel_branch}),
                     32'(e_mon.ctrl));
            check_eq("state", 32'(state_o), 32'(e_mon.st));
            check_eq("stall_cycles", 32'(stall_cycles), 32'(e_mon.stall));
            check_eq("miss_timeout", 32'(miss_timeout), 32'(e_mon.tmo));
        end
    end

    // Push the expectation for the current inputs, advance the model, then
    // move to just after the next rising edge.
    task automatic cycle();
        exp_t e;
        logic m, h, lu;
        logic [1:0] nxt;
        m  = !icache_hit || (mem_access && !dcache_hit);
        h  = ex_MemRead && ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        lu = 1'b0;
        nxt = S_RUN;
        if (reset)                 e.ctrl = C_DRAIN;
        else if (m)                begin e.ctrl = C_MISS; nxt = S_FREEZE; end
        else if (mem_branch_taken) begin e.ctrl = C_BR;   nxt = S_FLUSH;  end
        else if (h && (m_state == S_RUN || m_state == S_FREEZE)) begin
            e.ctrl = C_LU; nxt = S_LSTALL; lu = 1'b1;
        end
        else                       e.ctrl = C_DEF;
        e.st    = m_state;
        e.stall = m_stall;
        e.tmo   = m_tmo;
        sb.push_back(e);
        if (reset) begin
            m_state = S_RUN; m_stall = 16'd0; m_fcnt = 0; m_tmo = 1'b0;
        end else begin
            m_state = nxt;
            if ((m || lu) && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            m_fcnt = m ? ((m_fcnt < TMO) ? m_fcnt + 1 : TMO) : 0;
            if (m_fcnt >= TMO) m_tmo = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; icache_hit = 1; dcache_hit = 1; mem_access = 0;
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_MemRead = 0; ex_rt = 0; mem_branch_taken = 0;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        m_state = S_RUN; m_stall = 0; m_fcnt = 0; m_tmo = 0;
        @(posedge clk); #1;
        cycle();
        reset = 0;
        run_n(2);

        // Load-use on rs: one-cycle bubble, then defaults even with inputs held
        ex_MemRead = 1; ex_rt = 3'd2; id_rs = 3'd2; id_uses_rs = 1;
        run_n(3);
        // rt side, unused-source no-hazard, and r0 hazard
        idle_inputs(); ex_MemRead = 1; ex_rt = 3'd5; id_rt = 3'd5; id_uses_rt = 1;
        run_n(2);
        id_uses_rt = 0; id_rs = 3'd5; id_uses_rs = 0;
        run_n(2);
        idle_inputs(); ex_MemRead = 1; ex_rt = 3'd0; id_rs = 3'd0; id_uses_rs = 1;
        run_n(2);
        idle_inputs(); cycle();

        // Icache miss for 4 cycles
        icache_hit = 0; run_n(4);
        icache_hit = 1; run_n(2);

        // Branch with simultaneous load-use; hazard suppressed in FLUSH
        mem_branch_taken = 1; ex_MemRead = 1; ex_rt = 3'd4; id_rs = 3'd4; id_uses_rs = 1;
        cycle();
        mem_branch_taken = 0; cycle();
        cycle();
        // Branch held during a freeze, acted on at freeze exit; then back-to-back branch
        idle_inputs(); icache_hit = 0; mem_branch_taken = 1; run_n(2);
        icache_hit = 1; run_n(2);
        // Load-use held during a freeze, acted on at exit
        idle_inputs(); mem_access = 1; dcache_hit = 0; ex_MemRead = 1; ex_rt = 3'd1; id_rt = 3'd1; id_uses_rt = 1;
        run_n(2);
        dcache_hit = 1; run_n(3);
        idle_inputs();

        // Dcache miss long enough to reach the timeout, sticky afterwards
        mem_access = 1; dcache_hit = 0; run_n(TMO + 1);
        dcache_hit = 1; run_n(3);

        // Reset in FREEZE
        icache_hit = 0; run_n(3);
        reset = 1; cycle();
        reset = 0; icache_hit = 1; run_n(2);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            icache_hit = ($urandom_range(0, 7) != 0);
            mem_access = $urandom_range(0, 1);
            dcache_hit = ($urandom_range(0, 5) != 0);
            id_rs = 3'($urandom_range(0, 3)); id_rt = 3'($urandom_range(0, 3));
            ex_rt = 3'($urandom_range(0, 3));
            id_uses_rs = $urandom_range(0, 1); id_uses_rt = $urandom_range(0, 1);
            ex_MemRead = $urandom_range(0, 1);
            mem_branch_taken = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 60) == 0);
            cycle();
        end

        // Saturation of the stall counter
        idle_inputs(); reset = 1; cycle();
        reset = 0; icache_hit = 0; run_n(65540);
        icache_hit = 1; run_n(2);

        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
